timer_irq_dev: RTL and testbench
================================

Name: timer_irq_dev

Overview:
- Programmable down-counting timer peripheral on the CPU's memory-mapped device bus.
- It is the source of one HWInt line into the CP0 interrupt logic.
- The CPU programs it through the bridge using sw/lw to three word registers: CTRL, PRESET and COUNT.
- It raises irq when the count expires, either once (mode 0) or periodically (mode 1).

Parameters:
- PRESET_RST, 32'h0000_0000, reset value of PRESET.
- IRQ_MASK_RST, 1'b0, reset value of CTRL.IM.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- addr  input  2  word select, taken from bus address bits [3:2]: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- we  input  1  write enable from bridge, single-cycle.
- din  input  32  write data.
- dout  output  32  read data, combinational from addr.
- irq  output  1  interrupt request to CP0 HWInt.

Behaviour:
- Registers:
  - CTRL[3:0] = {IM, Mode[1:0], En}; upper 28 bits read 0.
  - PRESET is 32 bits.
  - COUNT is 32 bits and read-only.
  - State machine: IDLE, LOAD, CNT, INT.
- Reset (reset=0, asynchronous):
  - CTRL = {IRQ_MASK_RST, 2'b00, 1'b0}, PRESET = PRESET_RST, COUNT = 0.
  - irq_pend = 0, state = IDLE.
  - Outputs: irq = 0; dout reflects reset register values.
  - Reset asserted mid-count aborts immediately; no irq is produced afterwards.
- Reads (no side effects):
  - addr 0 -> {28'b0, CTRL}.
  - addr 1 -> PRESET.
  - addr 2 -> COUNT.
  - addr 3 -> 0.
- irq = irq_pend & CTRL.IM (combinational from registers, no extra latency).
- State transitions, one per posedge:
  - IDLE: if En -> LOAD, else stay.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT:
    - if !En -> IDLE, COUNT holds.
    - else if COUNT == 0 -> INT, irq_pend <= 1. (PRESET = 0 expires one cycle after LOAD.)
    - else if COUNT == 1 -> COUNT <= 0, stay in CNT.
    - else COUNT <= COUNT - 1.
- Correction: the COUNT == 1 case instead goes COUNT <= 0, -> INT, irq_pend <= 1. Expiry is therefore detected on the decrement to 0; the COUNT == 0 branch covers PRESET = 0 only.
- INT state:
  - Mode 0, 2 or 3: En <= 0, -> IDLE. irq_pend stays 1 until cleared by a CPU write.
  - Mode 1: irq_pend <= 0 (irq high exactly one cycle), -> LOAD (auto-reload).
- CPU writes (we=1):
  - addr 0: CTRL <= din[3:0], irq_pend <= 0, state <= IDLE. COUNT holds; a new count starts via LOAD if En=1.
  - addr 1: PRESET <= din, irq_pend <= 0. State and COUNT are unaffected; the new value takes effect at the next LOAD.
  - addr 2 or 3: ignored.
- Simultaneous events:
  - A CPU write in the same cycle as a state-machine update wins for every field it touches, including irq_pend and En.
  - A write to CTRL in the same cycle as expiry: the write wins, irq_pend = 0, state = IDLE.
- Arithmetic is unsigned 32-bit. COUNT never wraps below 0.
- Timing from a CTRL write that sets En at edge E0, with PRESET = N ≥ 1:
  - LOAD at E1, COUNT = N at E2, COUNT = 0 and irq_pend = 1 at E(N+2).
  - Mode 1 period is N+2 cycles.

Test Plan:
- Reset=0 mid-count (COUNT = 5, En = 1) -> COUNT = 0, CTRL = 0, irq = 0, and irq stays 0 for 20 cycles after release.
- PRESET = 3, CTRL = 0x9 (IM=1, mode 0, En=1) written at E0 -> COUNT reads 3,2,1,0 at E2..E5; irq = 1 from E5. CTRL reads 0x8 after E6. irq held until a write of CTRL = 0x8 clears it the next cycle.
- PRESET = 2, CTRL = 0xB (mode 1) -> irq one-cycle pulses at E4, E8, E12 (period 4). COUNT reloads to 2 every period.
- PRESET = 0, CTRL = 0x9 -> irq = 1 at E3. CTRL = 0x1 (IM=0) with PRESET = 3 -> expiry occurs and COUNT = 0 while irq stays 0; then writing CTRL = 0x8 leaves irq 0, because irq_pend was cleared by that write.
- CTRL write of 0x0 at the exact expiry edge (E5, PRESET = 3) -> irq never rises, state IDLE. PRESET write of 7 during counting -> current run unaffected; mode-1 next period is 9 cycles.
- Reads at addr 2/3 after writing din = 0xFFFFFFFF to them -> COUNT unchanged, addr 3 reads 0, and the CTRL read shows upper bits 0.

Source files
------------

// File: rtl/timer_irq_dev.sv
// Programmable down-counting timer on the device bus; drives one HWInt line into CP0.
// Latency: register writes take effect at the next posedge; dout and irq are combinational from registers.
// Backpressure: none; single-cycle writes are always accepted, reads have no side effects.
//
// Ports:
//   clk   - system clock, all state updates on posedge
//   reset - asynchronous active-low reset
//   addr  - word select (bus addr[3:2]): 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 reserved
//   we    - single-cycle write enable
//   din   - write data
//   dout  - read data for addr
//   irq   - interrupt request, irq_pend gated by CTRL.IM
module timer_irq_dev #(
  parameter logic [31:0] PRESET_RST   = 32'h0000_0000,
  parameter logic        IRQ_MASK_RST = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // CTRL layout: [3] IM, [2:1] Mode, [0] En
  logic [3:0]  ctrl_q,     ctrl_d;
  logic [31:0] preset_q,   preset_d;
  logic [31:0] count_q,    count_d;
  logic        irq_pend_q, irq_pend_d;
  state_t      state_q,    state_d;

  logic       ctrl_en;
  logic       ctrl_im;
  logic [1:0] ctrl_mode;
  logic       wr_ctrl;
  logic       wr_preset;

  assign ctrl_en   = ctrl_q[0];
  assign ctrl_mode = ctrl_q[2:1];
  assign ctrl_im   = ctrl_q[3];
  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);

  // Next-state: the counter state machine first, then CPU writes override
  // whatever fields they touch so software always wins a same-cycle race.
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_pend_d = irq_pend_q;
    state_d    = state_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_en) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end

      ST_CNT: begin
        if (!ctrl_en) begin
          state_d = ST_IDLE;
        end else if (count_q == 32'd0) begin
          // Only reachable with PRESET = 0: expire one cycle after LOAD.
          irq_pend_d = 1'b1;
          state_d    = ST_INT;
        end else if (count_q == 32'd1) begin
          // Expiry is flagged on the same edge COUNT reaches zero.
          count_d    = 32'd0;
          irq_pend_d = 1'b1;
          state_d    = ST_INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end

      ST_INT: begin
        if (ctrl_mode == MODE_PERIODIC) begin
          // Periodic: pend lasts exactly one cycle, then reload.
          irq_pend_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          // One-shot: disarm, leave pend for software to clear.
          ctrl_d[0] = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (wr_ctrl) begin
      // COUNT is frozen on a CTRL write; a fresh run reloads it via LOAD.
      ctrl_d     = din[3:0];
      count_d    = count_q;
      irq_pend_d = 1'b0;
      state_d    = ST_IDLE;
    end

    if (wr_preset) begin
      preset_d   = din;
      irq_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= {IRQ_MASK_RST, 2'b00, 1'b0};
      preset_q   <= PRESET_RST;
      count_q    <= 32'd0;
      irq_pend_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_pend_q <= irq_pend_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    dout = 32'd0;
    unique case (addr)
      ADDR_CTRL:   dout = {28'd0, ctrl_q};
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count_q;
      default:     dout = 32'd0;
    endcase
  end

  assign irq = irq_pend_q & ctrl_im;

endmodule

// File: tb/tb_timer_irq_dev.sv
// Testbench for timer_irq_dev.
// Expected values come from the timing rules of the timer, pushed as stimulus is driven.
// Outputs are sampled in the low phase of the clock, away from the active edge.
module tb_timer_irq_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_vec;
  int n_err;

  typedef struct {
    string       tag;
    logic        is_irq;
    logic [1:0]  a;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  timer_irq_dev #(
    .PRESET_RST   (32'h0000_0000),
    .IRQ_MASK_RST (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic exp_rd(input string tag, input logic [1:0] a, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.is_irq = 1'b0; e.a = a; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_irq(input string tag, input logic v);
    exp_t e;
    e.tag = tag; e.is_irq = 1'b1; e.a = 2'd0; e.val = {31'd0, v};
    sb.push_back(e);
  endtask

  // Pops every pending expectation and compares it with the live DUT output.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.is_irq) addr = e.a;
      #1;
      if (e.is_irq) chk(e.tag, {31'd0, irq}, e.val);
      else          chk(e.tag, dout, e.val);
    end
  endtask

  // Called in the low phase; the write lands on the next posedge, returns at the following negedge.
  task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; din = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    addr  = 2'd0;
    we    = 1'b0;
    din   = 32'd0;
    step(2);

    // Reset state
    exp_rd("rst_ctrl", 2'd0, 32'h0);
    exp_rd("rst_preset", 2'd1, 32'h0);
    exp_rd("rst_count", 2'd2, 32'h0);
    exp_rd("rst_rsvd", 2'd3, 32'h0);
    exp_irq("rst_irq", 1'b0);
    drain();
    reset = 1'b1;
    step(1);

    // Reset mid-count aborts the run
    cpu_wr(2'd1, 32'd8);
    cpu_wr(2'd0, 32'h9);          // E0
    step(5);                      // after E5: COUNT = 8-3
    exp_rd("midcnt_count", 2'd2, 32'd5);
    drain();
    reset = 1'b0;
    exp_rd("arst_count", 2'd2, 32'd0);
    exp_rd("arst_ctrl", 2'd0, 32'd0);
    exp_irq("arst_irq", 1'b0);
    drain();
    step(2);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      exp_irq($sformatf("post_rst_irq_c%0d", c), 1'b0);
      drain();
    end

    // One-shot, PRESET = 3
    cpu_wr(2'd1, 32'd3);
    cpu_wr(2'd0, 32'h9);          // E0
    step(1);
    for (int e = 2; e <= 5; e++) begin
      step(1);
      exp_rd($sformatf("os_count_e%0d", e), 2'd2, 32'(5 - e));
      exp_irq($sformatf("os_irq_e%0d", e), e == 5);
      drain();
    end
    step(1);                      // E6
    exp_rd("os_ctrl_e6", 2'd0, 32'h8);
    exp_irq("os_irq_held_e6", 1'b1);
    drain();
    step(3);
    exp_irq("os_irq_held_e9", 1'b1);
    drain();
    cpu_wr(2'd0, 32'h8);
    exp_irq("os_irq_cleared", 1'b0);
    drain();

    // Periodic, PRESET = 2: pulses every 4 cycles
    cpu_wr(2'd1, 32'd2);
    cpu_wr(2'd0, 32'hB);          // E0
    for (int e = 1; e <= 14; e++) begin
      step(1);
      exp_irq($sformatf("per_irq_e%0d", e), (e % 4) == 0);
      if (e == 6 || e == 10) exp_rd($sformatf("per_reload_e%0d", e), 2'd2, 32'd2);
      drain();
    end
    cpu_wr(2'd0, 32'h0);

    // PRESET = 0 expires one cycle after LOAD
    cpu_wr(2'd1, 32'd0);
    cpu_wr(2'd0, 32'h9);          // E0
    for (int e = 1; e <= 3; e++) begin
      step(1);
      exp_irq($sformatf("p0_irq_e%0d", e), e == 3);
      drain();
    end
    cpu_wr(2'd0, 32'h0);

    // Masked expiry, then unmask via a CTRL write that also clears pend
    cpu_wr(2'd1, 32'd3);
    cpu_wr(2'd0, 32'h1);          // E0
    step(5);                      // E5
    exp_rd("msk_count_e5", 2'd2, 32'd0);
    exp_irq("msk_irq_e5", 1'b0);
    drain();
    step(1);                      // E6: one-shot disarms En
    exp_rd("msk_ctrl_e6", 2'd0, 32'h0);
    drain();
    cpu_wr(2'd0, 32'h8);
    exp_irq("msk_unmask_irq", 1'b0);
    drain();
    step(2);
    exp_irq("msk_unmask_irq_later", 1'b0);
    drain();

    // CTRL write of 0 at the exact expiry edge
    cpu_wr(2'd0, 32'h9);          // E0, PRESET still 3
    step(4);                      // after E4
    exp_rd("race_count_e4", 2'd2, 32'd1);
    drain();
    cpu_wr(2'd0, 32'h0);          // E5
    for (int c = 0; c < 5; c++) begin
      exp_irq($sformatf("race_irq_c%0d", c), 1'b0);
      drain();
      step(1);
    end
    exp_rd("race_ctrl", 2'd0, 32'h0);
    drain();

    // PRESET rewritten mid-run: current period unchanged, next one N+2 = 9
    cpu_wr(2'd0, 32'hB);          // E0, PRESET = 3
    step(2);                      // after E2
    cpu_wr(2'd1, 32'd7);          // E3
    step(2);                      // E5
    exp_irq("pw_irq_e5", 1'b1);
    drain();
    step(1);
    exp_irq("pw_irq_e6", 1'b0);
    drain();
    step(1);
    exp_rd("pw_count_e7", 2'd2, 32'd7);
    drain();
    step(6);
    exp_irq("pw_irq_e13", 1'b0);
    drain();
    step(1);
    exp_irq("pw_irq_e14", 1'b1);
    drain();
    step(1);
    exp_irq("pw_irq_e15", 1'b0);
    drain();
    cpu_wr(2'd0, 32'h0);

    // Writes to COUNT / reserved are ignored; CTRL upper bits read 0
    cpu_wr(2'd1, 32'd5);
    cpu_wr(2'd0, 32'h1);          // E0
    step(3);                      // after E3: COUNT = 4
    cpu_wr(2'd0, 32'h0);          // E4: COUNT frozen
    exp_rd("ro_count_frozen", 2'd2, 32'd4);
    drain();
    cpu_wr(2'd2, 32'hFFFF_FFFF);
    cpu_wr(2'd3, 32'hFFFF_FFFF);
    exp_rd("ro_count_after_wr", 2'd2, 32'd4);
    exp_rd("ro_rsvd", 2'd3, 32'd0);
    exp_rd("ro_preset", 2'd1, 32'd5);
    drain();
    cpu_wr(2'd0, 32'hFFFF_FFFF);
    exp_rd("ro_ctrl_upper", 2'd0, 32'h0000_000F);
    drain();
    cpu_wr(2'd0, 32'h0);

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d entries, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
